// File: rtl/keypad_pkg.sv
// Shared types, default timing constants and column-decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned SCAN_DIV_DEF = 50000;
  localparam int unsigned DEB_CNT_DEF  = 20;
  localparam int unsigned KP_W         = 4;
  localparam int unsigned IDX_W        = 2;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } kp_state_e;

  // True when exactly one column line is pulled low.
  function automatic logic single_low(input logic [KP_W-1:0] c);
    return ($countones(~c) == 1);
  endfunction

  function automatic logic [IDX_W-1:0] low_index(input logic [KP_W-1:0] c);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = KP_W - 1; i >= 0; i--) begin
      if (!c[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Column pattern with only the given column low.
  function automatic logic [KP_W-1:0] col_mask(input logic [IDX_W-1:0] idx);
    return ~(KP_W'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle tick every DIV clk_50m cycles.
module scan_tick #(
  parameter int unsigned DIV = keypad_pkg::SCAN_DIV_DEF
) (
  input  logic clk_50m,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row rotation, press/release debounce, one-pulse key report.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  parameter int unsigned DEB_CNT  = DEB_CNT_DEF
) (
  input  logic            clk_50m,
  input  logic            reset,
  output logic [KP_W-1:0] row_out,
  input  logic [KP_W-1:0] col_in,
  output logic [KP_W-1:0] key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int unsigned DW = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT);

  logic            tick;
  logic [KP_W-1:0] sync1_q, sync2_q;
  kp_state_e       state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [DW-1:0]   rel_q, rel_d;
  logic [KP_W-1:0] row_out_q, row_out_d;
  logic [KP_W-1:0] key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  logic            col_single_c, col_match_c, col_rel_c;
  logic [DW-1:0]   deb_inc_c, rel_inc_c;

  scan_tick #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk_50m (clk_50m),
    .reset   (reset),
    .tick    (tick)
  );

  // Column decode and saturating counter increments.
  always_comb begin
    col_single_c = single_low(sync2_q);
    col_match_c  = (sync2_q == col_mask(col_q));
    col_rel_c    = sync2_q[col_q];
    deb_inc_c    = (deb_q == DEB_MAX) ? deb_q : deb_q + DW'(1);
    rel_inc_c    = (rel_q == DEB_MAX) ? rel_q : rel_q + DW'(1);
  end

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) state_q <= ST_SCAN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        ST_SCAN:     if (col_single_c) state_d = ST_DEBOUNCE;
        ST_DEBOUNCE: begin
          if (!col_match_c)            state_d = ST_SCAN;
          else if (deb_inc_c == DEB_MAX) state_d = ST_PRESSED;
        end
        ST_PRESSED:  if (col_rel_c && (rel_inc_c == DEB_MAX)) state_d = ST_SCAN;
        default:     state_d = ST_SCAN;
      endcase
    end
  end

  // Datapath updates; row advances whenever the scanner leaves or stays in SCAN without a key.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (col_single_c) begin
            col_d = low_index(sync2_q);
            deb_d = '0;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (col_match_c) begin
            deb_d = deb_inc_c;
            if (deb_inc_c == DEB_MAX) begin
              key_valid_d = 1'b1;
              key_code_d  = {row_q, col_q};
              key_held_d  = 1'b1;
            end
          end else begin
            deb_d = '0;
            row_d = row_q + IDX_W'(1);
          end
        end
        ST_PRESSED: begin
          if (col_rel_c) begin
            rel_d = rel_inc_c;
            if (rel_inc_c == DEB_MAX) begin
              rel_d      = '0;
              key_held_d = 1'b0;
              row_d      = row_q + IDX_W'(1);
            end
          end else begin
            rel_d = '0;
          end
        end
        default: begin
          row_d      = '0;
          key_held_d = 1'b0;
        end
      endcase
    end
    row_out_d = ~(KP_W'(1) << row_d);
  end

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      row_q       <= '0;
      col_q       <= '0;
      deb_q       <= '0;
      rel_q       <= '0;
      row_out_q   <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1_q     <= col_in;
      sync2_q     <= sync1_q;
      row_q       <= row_d;
      col_q       <= col_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      row_out_q   <= row_out_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
